mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port (data/fetch) single-RAM arbiter.
// The tie-break policy is selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
package mem_arbiter_pkg;

    localparam int MEM_ARB_ADDR_W = 10;
    localparam int MEM_ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_F = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the data and fetch ports.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the port not served last; otherwise data always wins.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   d_req,
    input  logic   f_req,
    input  owner_t last_served,
    output owner_t winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = OWN_D;
        if (d_req && f_req) begin
            winner = (last_served == OWN_D) ? OWN_F : OWN_D;
        end else if (f_req) begin
            winner = OWN_F;
        end
    end
`else
    // Fixed priority: fetch only wins when the data port is quiet.
    always_comb begin
        winner = OWN_D;
        if (!d_req && f_req) begin
            winner = OWN_F;
        end
    end

    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a data (MEM-stage) port and an instruction-fetch port onto one
// synchronous RAM; 2 cycles per transaction. Tie-break set by MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,

    input  logic              flush,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, last_q, winner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              flushed_q;

    logic any_req, take, in_access, in_resp, own_f;

    assign any_req   = d_req | f_req;
    assign take      = any_req && ((state_q == IDLE) || (state_q == RESP));
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);
    assign own_f     = (owner_q == OWN_F);

    mem_arb_pick u_pick (
        .d_req       (d_req),
        .f_req       (f_req),
        .last_served (last_q),
        .winner      (winner)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = any_req ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Payload is captured only at arbitration; requesters hold it until gnt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_D;
            last_q  <= OWN_F;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            owner_q <= winner;
            last_q  <= winner;
            if (winner == OWN_D) begin
                we_q    <= d_we;
                addr_q  <= d_addr[ADDR_W+1:2];
                wdata_q <= DATA_W'(d_wdata);
            end else begin
                we_q    <= 1'b0;
                addr_q  <= f_addr[ADDR_W+1:2];
                wdata_q <= '0;
            end
        end
    end

    // A flush seen during ACCESS is remembered so the response a cycle later is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flushed_q <= 1'b0;
        end else if (take) begin
            flushed_q <= 1'b0;
        end else if ((in_access || in_resp) && own_f && flush) begin
            flushed_q <= 1'b1;
        end
    end

    always_comb begin
        ram_en    = in_access;
        ram_we    = in_access && !own_f && we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;

        d_gnt     = in_access && !own_f;
        f_gnt     = in_access && own_f;
        d_rvalid  = in_resp && !own_f;
        f_rvalid  = in_resp && own_f && !flushed_q && !flush;

        d_rdata   = d_rvalid ? ram_rdata : '0;
        f_rdata   = f_rvalid ? ram_rdata : '0;
    end

    // Byte-offset and out-of-range address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{d_addr[31:ADDR_W+2], d_addr[1:0],
                                f_addr[31:ADDR_W+2], f_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// request sets, checked against a transaction-level model and a sparse RAM.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          d_req, d_we, f_req, flush;
    logic [31:0]   d_addr, d_wdata, f_addr;
    logic          d_gnt, d_rvalid, f_gnt, f_rvalid;
    logic [DW-1:0] d_rdata, f_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int total = 0;
    int bad   = 0;
    bit last_f;

    logic [31:0] ram     [int];
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .flush     (flush),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    function automatic logic [31:0] pattern(int idx);
        return 32'hC0DE_0000 ^ (32'(idx) * 32'h0001_0101);
    endfunction

    // Synchronous RAM: read data appears the cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram.exists(int'(ram_addr)) ? ram[int'(ram_addr)] : pattern(int'(ram_addr));
            if (ram_we) ram[int'(ram_addr)] = ram_wdata;
        end
    end

    function automatic logic [31:0] ref_read(int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : pattern(idx);
    endfunction

    // Tie-break rule; returns 1 when fetch should win.
    function automatic bit pick_f(bit dp, bit fp);
        if (dp && fp) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return !last_f;
`else
            return 1'b0;
`endif
        end
        return fp;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Port exclusivity and read-only fetch, sampled away from both edges.
    always @(negedge clk) begin
        #2;
        check("gnt_excl", 64'(d_gnt & f_gnt), 64'd0);
        check("rvalid_excl", 64'(d_rvalid & f_rvalid), 64'd0);
        if (f_gnt) check("fetch_no_we", 64'(ram_we), 64'd0);
    end

    task automatic check_all_zero(input string tag);
        logic [63:0] acc;
        acc = 64'({d_gnt, f_gnt, d_rvalid, f_rvalid, ram_en, ram_we});
        check({tag, "_ctl"}, acc, 64'd0);
        check({tag, "_addr"}, 64'(ram_addr), 64'd0);
        check({tag, "_wdata"}, 64'(ram_wdata), 64'd0);
        check({tag, "_rdata"}, 64'({d_rdata, f_rdata}), 64'd0);
    endtask

    // Issue a request set from IDLE and follow it until both ports are served.
    // flush_mode: 0 none, 1 flush during fetch ACCESS, 2 flush during fetch RESP.
    task automatic serve(input bit dp, input txn_t dt, input bit fp, input txn_t ft,
                         input int flush_mode);
        bit            pend_d, pend_f, w;
        txn_t          t;
        logic [AW-1:0] widx;
        logic [31:0]   exp_rd;
        d_req = dp; d_we = dt.we; d_addr = dt.addr; d_wdata = dt.wdata;
        f_req = fp; f_addr = ft.addr;
        pend_d = dp; pend_f = fp;
        while (pend_d || pend_f) begin
            w = pick_f(pend_d, pend_f);
            t = w ? ft : dt;
            widx = t.addr[AW+1:2];
            @(negedge clk);
            flush = 1'b0;
            #1;
            check("d_gnt", 64'(d_gnt), 64'(!w));
            check("f_gnt", 64'(f_gnt), 64'(w));
            check("ram_en", 64'(ram_en), 64'd1);
            check("ram_we", 64'(ram_we), 64'(t.we && !w));
            check("ram_addr", 64'(ram_addr), 64'(widx));
            if (t.we && !w) check("ram_wdata", 64'(ram_wdata), 64'(t.wdata));
            exp_rd = ref_read(int'(widx));
            if (t.we && !w) ref_mem[int'(widx)] = t.wdata;
            last_f = w;
            if (w) begin f_req = 1'b0; pend_f = 1'b0; end
            else   begin d_req = 1'b0; pend_d = 1'b0; end
            if (w && flush_mode == 1) flush = 1'b1;
            @(negedge clk);
            flush = (w && flush_mode == 2);
            #1;
            check("resp_ram_en", 64'(ram_en), 64'd0);
            check("d_rvalid", 64'(d_rvalid), 64'(!w));
            check("f_rvalid", 64'(f_rvalid), 64'(w && flush_mode == 0));
            if (!w && !t.we) check("d_rdata", 64'(d_rdata), 64'(exp_rd));
            if (w && flush_mode == 0) check("f_rdata", 64'(f_rdata), 64'(exp_rd));
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("idle_ram_en", 64'(ram_en), 64'd0);
    endtask

    // Both ports request continuously for n transactions (back-to-back stream).
    task automatic hold_both(input int n, input txn_t dt, input txn_t ft);
        bit          w;
        logic [31:0] exp_rd;
        txn_t        t;
        d_req = 1'b1; d_we = 1'b0; d_addr = dt.addr; d_wdata = dt.wdata;
        f_req = 1'b1; f_addr = ft.addr;
        for (int k = 0; k < n; k++) begin
            w = pick_f(1'b1, 1'b1);
            t = w ? ft : dt;
            @(negedge clk);
            #1;
            check("hold_d_gnt", 64'(d_gnt), 64'(!w));
            check("hold_f_gnt", 64'(f_gnt), 64'(w));
            check("hold_ram_addr", 64'(ram_addr), 64'(t.addr[AW+1:2]));
            exp_rd = ref_read(int'(t.addr[AW+1:2]));
            last_f = w;
            @(negedge clk);
            if (k == n - 1) begin d_req = 1'b0; f_req = 1'b0; end
            #1;
            check("hold_d_rvalid", 64'(d_rvalid), 64'(!w));
            check("hold_f_rvalid", 64'(f_rvalid), 64'(w));
            check("hold_rdata", 64'(w ? f_rdata : d_rdata), 64'(exp_rd));
        end
        @(negedge clk);
        #1;
        check("hold_idle", 64'(ram_en), 64'd0);
    endtask

    initial begin
        txn_t dt, ft, none;
        bit   dp, fp;
        int   fm;

        none = '0;
        reset = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        f_req = 1'b0; f_addr = '0; flush = 1'b0;
        last_f = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // Write then read back 0x10: word 4, 2-cycle latency.
        dt = '{we: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF};
        serve(1'b1, dt, 1'b0, none, 0);
        dt = '{we: 1'b0, addr: 32'h10, wdata: 32'h0};
        serve(1'b1, dt, 1'b0, none, 0);
        check("readback_ref", 64'(ref_read(4)), 64'h0000_0000_DEAD_BEEF);

        // Reset during ACCESS of a data read.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        @(negedge clk);
        #1;
        check("pre_reset_gnt", 64'(d_gnt), 64'd1);
        reset = 1'b0;
        d_req = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        #1;
        check("reset_no_rvalid", 64'(d_rvalid), 64'd0);
        reset = 1'b1;
        last_f = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_idle", 64'(ram_en), 64'd0);

        // Continuous tie: RR alternates D,F,..., fixed serves D only.
        dt = '{we: 1'b0, addr: 32'h10, wdata: 32'h0};
        ft = '{we: 1'b0, addr: 32'h80, wdata: 32'h0};
        hold_both(6, dt, ft);

        // Fetch flushed in RESP, then in ACCESS, then a normal fetch.
        ft = '{we: 1'b0, addr: 32'h40, wdata: 32'h0};
        serve(1'b0, none, 1'b1, ft, 2);
        serve(1'b0, none, 1'b1, ft, 1);
        serve(1'b0, none, 1'b1, ft, 0);

        // Simultaneous request with data write and flushed fetch: data unaffected.
        dt = '{we: 1'b1, addr: 32'hFFFF_F004, wdata: 32'h1234_5678};
        serve(1'b1, dt, 1'b1, ft, 2);

        // Randomized request sets; high address bits are noise that must wrap away.
        for (int i = 0; i < 60; i++) begin
            do begin
                dp = 1'($urandom);
                fp = 1'($urandom);
            end while (!dp && !fp);
            dt.we    = 1'($urandom);
            dt.addr  = $urandom;
            dt.addr[AW+1:2] = AW'($urandom_range(0, 7));
            dt.wdata = $urandom;
            ft.we    = 1'b0;
            ft.addr  = $urandom;
            ft.addr[AW+1:2] = AW'($urandom_range(0, 7));
            ft.wdata = '0;
            fm = (fp && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            serve(dp, dt, fp, ft, fm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
